// File: rtl/tlb_array.sv
// TLB entry storage with CP0 write/read ports, a multi-cycle tlbp probe engine and a single-cycle search port.
// Read/search are combinational; a probe completes 2..TLBNUM/LANES+1 cycles after the cycle its start is accepted.
// A probe start is taken only while probe_ready; a write during SEARCH restarts the scan and can stall it indefinitely.
module tlb_array #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM),
    parameter int LANES        = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    we,
    input  logic [TLBNUM_WIDTH-1:0] w_index,
    input  logic [18:0]             w_vpn2,
    input  logic [7:0]              w_asid,
    input  logic                    w_g,
    input  logic [19:0]             w_pfn0,
    input  logic [2:0]              w_c0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [19:0]             w_pfn1,
    input  logic [2:0]              w_c1,
    input  logic                    w_d1,
    input  logic                    w_v1,

    input  logic [TLBNUM_WIDTH-1:0] r_index,
    output logic [18:0]             r_vpn2,
    output logic [7:0]              r_asid,
    output logic                    r_g,
    output logic [19:0]             r_pfn0,
    output logic [2:0]              r_c0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [19:0]             r_pfn1,
    output logic [2:0]              r_c1,
    output logic                    r_d1,
    output logic                    r_v1,

    input  logic                    probe_start,
    input  logic [18:0]             probe_vpn2,
    input  logic [7:0]              probe_asid,
    output logic                    probe_ready,
    output logic                    probe_done,
    output logic [TLBNUM_WIDTH:0]   probe_result,

    input  logic [18:0]             s_vpn2,
    input  logic                    s_odd,
    input  logic [7:0]              s_asid,
    output logic                    s_found,
    output logic [TLBNUM_WIDTH-1:0] s_index,
    output logic [19:0]             s_pfn,
    output logic [2:0]              s_c,
    output logic                    s_d,
    output logic                    s_v
);

    localparam int NGROUP = TLBNUM / LANES;
    localparam int GW     = (NGROUP > 1) ? $clog2(NGROUP) : 1;
    localparam logic [GW-1:0] LAST_GROUP = GW'(NGROUP - 1);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    // Page valid/dirty bits deliberately take no part in the match.
    function automatic logic tag_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                       input logic [7:0] asid);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

    tlb_entry_t entry_q [TLBNUM];
    tlb_entry_t w_entry;
    tlb_entry_t r_entry;
    tlb_entry_t s_sel;
    logic                    s_hit;
    logic [TLBNUM_WIDTH-1:0] s_idx;

    state_t                  state_q;
    logic [GW-1:0]           g_q;
    logic [18:0]             key_vpn2_q;
    logic [7:0]              key_asid_q;
    logic                    grp_hit;
    logic [TLBNUM_WIDTH-1:0] grp_idx;
    logic [TLBNUM_WIDTH-1:0] lane_idx;

    assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                       pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                       pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

    // Entry storage: reset zeroes every field, a write replaces the whole entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= '0;
            end
        end else if (we) begin
            entry_q[w_index] <= w_entry;
        end
    end

    assign r_entry = entry_q[r_index];
    assign r_vpn2  = r_entry.vpn2;
    assign r_asid  = r_entry.asid;
    assign r_g     = r_entry.g;
    assign r_pfn0  = r_entry.pfn0;
    assign r_c0    = r_entry.c0;
    assign r_d0    = r_entry.d0;
    assign r_v0    = r_entry.v0;
    assign r_pfn1  = r_entry.pfn1;
    assign r_c1    = r_entry.c1;
    assign r_d1    = r_entry.d1;
    assign r_v1    = r_entry.v1;

    // Translation search over all entries; scanning downwards lets the lowest match win.
    always_comb begin
        s_hit = 1'b0;
        s_idx = '0;
        s_sel = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tag_match(entry_q[i], s_vpn2, s_asid)) begin
                s_hit = 1'b1;
                s_idx = TLBNUM_WIDTH'(i);
                s_sel = entry_q[i];
            end
        end
    end

    // With no hit s_sel is all zero, so every page output falls to 0 on its own.
    assign s_found = s_hit;
    assign s_index = s_idx;
    assign s_pfn   = s_odd ? s_sel.pfn1 : s_sel.pfn0;
    assign s_c     = s_odd ? s_sel.c1   : s_sel.c0;
    assign s_d     = s_odd ? s_sel.d1   : s_sel.d0;
    assign s_v     = s_odd ? s_sel.v1   : s_sel.v0;

    // Probe lane compare for the current group, lowest lane taking priority.
    always_comb begin
        grp_hit  = 1'b0;
        grp_idx  = '0;
        lane_idx = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            lane_idx = TLBNUM_WIDTH'(int'(g_q) * LANES + l);
            if (tag_match(entry_q[lane_idx], key_vpn2_q, key_asid_q)) begin
                grp_hit = 1'b1;
                grp_idx = lane_idx;
            end
        end
    end

    // Probe FSM: a write during SEARCH invalidates this cycle's compare and rescans from group 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            g_q          <= '0;
            key_vpn2_q   <= '0;
            key_asid_q   <= '0;
            probe_ready  <= 1'b1;
            probe_done   <= 1'b0;
            probe_result <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    probe_done <= 1'b0;
                    if (probe_start) begin
                        key_vpn2_q  <= probe_vpn2;
                        key_asid_q  <= probe_asid;
                        g_q         <= '0;
                        probe_ready <= 1'b0;
                        state_q     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (we) begin
                        g_q <= '0;
                    end else if (grp_hit) begin
                        probe_result <= {1'b0, grp_idx};
                        probe_done   <= 1'b1;
                        state_q      <= DONE;
                    end else if (g_q == LAST_GROUP) begin
                        probe_result <= {1'b1, {TLBNUM_WIDTH{1'b0}}};
                        probe_done   <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        g_q <= g_q + GW'(1);
                    end
                end
                DONE: begin
                    probe_done  <= 1'b0;
                    probe_ready <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    probe_done  <= 1'b0;
                    probe_ready <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_array.sv
// Bench for tlb_array: table of search/probe vectors plus hand-written multi-cycle sequences.
// Probe results are queued with their expected completion cycle and checked when probe_done fires.
// Any probe_done with nothing queued is reported as a miscompare.
module tb_tlb_array;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [TW-1:0] w_index;
    logic [18:0]   w_vpn2;
    logic [7:0]    w_asid;
    logic          w_g;
    logic [19:0]   w_pfn0, w_pfn1;
    logic [2:0]    w_c0, w_c1;
    logic          w_d0, w_v0, w_d1, w_v1;
    logic [TW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    logic          r_g;
    logic [19:0]   r_pfn0, r_pfn1;
    logic [2:0]    r_c0, r_c1;
    logic          r_d0, r_v0, r_d1, r_v1;
    logic          probe_start;
    logic [18:0]   probe_vpn2;
    logic [7:0]    probe_asid;
    logic          probe_ready, probe_done;
    logic [TW:0]   probe_result;
    logic [18:0]   s_vpn2;
    logic          s_odd;
    logic [7:0]    s_asid;
    logic          s_found;
    logic [TW-1:0] s_index;
    logic [19:0]   s_pfn;
    logic [2:0]    s_c;
    logic          s_d, s_v;

    tlb_array #(.TLBNUM(16), .TLBNUM_WIDTH(TW), .LANES(4)) dut (
        .clk(clk), .reset(reset),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .probe_start(probe_start), .probe_vpn2(probe_vpn2), .probe_asid(probe_asid),
        .probe_ready(probe_ready), .probe_done(probe_done), .probe_result(probe_result),
        .s_vpn2(s_vpn2), .s_odd(s_odd), .s_asid(s_asid), .s_found(s_found),
        .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [TW:0] res;
        int          when;
    } exp_t;
    exp_t sb[$];
    exp_t exp_mon;
    exp_t exp_drv;

    typedef struct {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        odd;
        logic        found;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic [4:0]  pres;
        int          lat;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Written entries carry fixed page attributes: even c=1 d=1 v=1, odd c=6 d=0 v=0.
    task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                      input logic g, input logic [19:0] p0, input logic [19:0] p1);
        we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = p0; w_c0 = 3'd1; w_d0 = 1'b1; w_v0 = 1'b1;
        w_pfn1 = p1; w_c1 = 3'd6; w_d1 = 1'b0; w_v1 = 1'b0;
        step();
        we = 1'b0;
    endtask

    task automatic start_probe(input logic [18:0] vpn2, input logic [7:0] asid, input logic push,
                               input logic [4:0] res, input int lat);
        probe_start = 1'b1; probe_vpn2 = vpn2; probe_asid = asid;
        if (push) begin
            exp_drv.res  = res;
            exp_drv.when = cyc + lat;
            sb.push_back(exp_drv);
        end
        step();
        probe_start = 1'b0;
        chk("probe_ready_busy", 32'(probe_ready), 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL probe_timeout: got no probe_done, want %0d pending results", sb.size());
            sb.delete();
        end else begin
            chk("probe_ready_after_done", 32'(probe_ready), 32'd1);
        end
    endtask

    // Scoreboard side: every probe_done pops one expected result and completion cycle.
    always @(negedge clk) begin
        if (probe_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_probe_done: got done with result 0x%0h, want no done (cycle %0d)",
                         probe_result, cyc);
            end else begin
                exp_mon = sb.pop_front();
                chk("probe_result", 32'(probe_result), 32'(exp_mon.res));
                chk("probe_done_cycle", 32'(cyc), 32'(exp_mon.when));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want bench end");
        $fatal(1, "watchdog");
    end

    initial begin
        //                     vpn2       asid   odd   fnd   idx    pfn         c     d     v     pres   lat
        vt[0] = '{19'h12345, 8'd3,    1'b0, 1'b1, 4'd5,  20'h00A05, 3'd1, 1'b1, 1'b1, 5'h05, 3};
        vt[1] = '{19'h12345, 8'd4,    1'b0, 1'b0, 4'd0,  20'h00000, 3'd0, 1'b0, 1'b0, 5'h10, 5};
        vt[2] = '{19'h2AAAA, 8'h55,   1'b1, 1'b1, 4'd9,  20'h00B09, 3'd6, 1'b0, 1'b0, 5'h09, 4};
        vt[3] = '{19'h2AAAA, 8'd7,    1'b0, 1'b1, 4'd9,  20'h00A09, 3'd1, 1'b1, 1'b1, 5'h09, 4};
        vt[4] = '{19'h33333, 8'd1,    1'b1, 1'b1, 4'd2,  20'h00B02, 3'd6, 1'b0, 1'b0, 5'h02, 2};
        vt[5] = '{19'h33333, 8'd2,    1'b0, 1'b0, 4'd0,  20'h00000, 3'd0, 1'b0, 1'b0, 5'h10, 5};
        vt[6] = '{19'h00000, 8'd0,    1'b0, 1'b1, 4'd0,  20'h00000, 3'd0, 1'b0, 1'b0, 5'h00, 2};
        vt[7] = '{19'h12345, 8'd3,    1'b1, 1'b1, 4'd5,  20'h00B05, 3'd6, 1'b0, 1'b0, 5'h05, 3};

        reset = 1'b1; we = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
        w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
        w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
        r_index = '0; probe_start = 1'b0; probe_vpn2 = '0; probe_asid = '0;
        s_vpn2 = '0; s_odd = 1'b0; s_asid = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_probe_ready", 32'(probe_ready), 32'd1);
        chk("reset_probe_done", 32'(probe_done), 32'd0);
        chk("reset_probe_result", 32'(probe_result), 32'd0);

        wr(4'd5,  19'h12345, 8'd3, 1'b0, 20'h00A05, 20'h00B05);
        wr(4'd9,  19'h2AAAA, 8'd7, 1'b1, 20'h00A09, 20'h00B09);
        wr(4'd2,  19'h33333, 8'd1, 1'b0, 20'h00A02, 20'h00B02);
        wr(4'd14, 19'h33333, 8'd1, 1'b0, 20'h00A0E, 20'h00B0E);
        r_index = 4'd5;
        #1;
        chk("read_idx5_vpn2", 32'(r_vpn2), 32'h12345);
        chk("read_idx5_asid", 32'(r_asid), 32'd3);
        chk("read_idx5_v0", 32'(r_v0), 32'd1);

        for (int i = 0; i < 8; i++) begin
            s_vpn2 = vt[i].vpn2; s_asid = vt[i].asid; s_odd = vt[i].odd;
            #1;
            chk("s_found", 32'(s_found), 32'(vt[i].found));
            chk("s_index", 32'(s_index), 32'(vt[i].idx));
            chk("s_pfn", 32'(s_pfn), 32'(vt[i].pfn));
            chk("s_c", 32'(s_c), 32'(vt[i].c));
            chk("s_d", 32'(s_d), 32'(vt[i].d));
            chk("s_v", 32'(s_v), 32'(vt[i].v));
            start_probe(vt[i].vpn2, vt[i].asid, 1'b1, vt[i].pres, vt[i].lat);
            wait_idle();
        end

        // Removing the lower duplicate exposes the higher one.
        wr(4'd2, 19'h01111, 8'd1, 1'b0, 20'h00A02, 20'h00B02);
        s_vpn2 = 19'h33333; s_asid = 8'd1; s_odd = 1'b0;
        #1;
        chk("prio_s_found", 32'(s_found), 32'd1);
        chk("prio_s_index", 32'(s_index), 32'd14);
        chk("prio_s_pfn", 32'(s_pfn), 32'h00A0E);
        start_probe(19'h33333, 8'd1, 1'b1, 5'h0E, 5);
        wait_idle();

        // Write in the first SEARCH cycle restarts the scan; a start while busy is dropped.
        start_probe(19'h12345, 8'd3, 1'b1, 5'h05, 4);
        wr(4'd1, 19'h04444, 8'd0, 1'b0, 20'h00111, 20'h00222);
        probe_start = 1'b1; probe_vpn2 = 19'h33333; probe_asid = 8'd1;
        step();
        probe_start = 1'b0;
        chk("busy_probe_ready", 32'(probe_ready), 32'd0);
        wait_idle();
        r_index = 4'd1;
        #1;
        chk("write_during_search_vpn2", 32'(r_vpn2), 32'h04444);

        // Reset two cycles into a probe: back to idle, no done pulse, storage cleared.
        start_probe(19'h12345, 8'd4, 1'b0, 5'h00, 0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_probe_ready", 32'(probe_ready), 32'd1);
        chk("midreset_probe_done", 32'(probe_done), 32'd0);
        chk("midreset_probe_result", 32'(probe_result), 32'd0);
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #1;
            chk("reset_entry_vpn2", 32'(r_vpn2), 32'd0);
            chk("reset_entry_fields",
                32'(|{r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}), 32'd0);
        end
        s_vpn2 = 19'h12345; s_asid = 8'd3; s_odd = 1'b0;
        #1;
        chk("reset_search_miss", 32'(s_found), 32'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
